fetch_ctrl: RTL and testbench

- Sequencing controller for the instruction-fetch stage.
- Generates `pc_sel`, `stall_if` and `flush_if` for the fetch block.
- Models instruction-memory read latency with an internal wait counter.
- Arbitrates redirect requests from decode (branch/JAL/JALR) against pipeline stalls, and keeps redirect/bubble performance counters.

---
 rtl/fetch_ctrl_if.sv | 27 ++
 rtl/fetch_ctrl.sv | 140 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// Handshake bundle between decode/memory and the fetch sequencing controller.
// The master side drives decode requests and stalls; the slave side is the controller.
interface fetch_ctrl_if #(
    parameter int XLEN = 32
);
    logic            branch_taken;
    logic            jal;
    logic            jalr;
    logic            stall_hazard;
    logic            stall_mem;
    logic [1:0]      pc_sel;
    logic            stall_if;
    logic            flush_if;
    logic            fetch_valid;
    logic [XLEN-1:0] redirect_count;
    logic [XLEN-1:0] bubble_count;

    modport master (
        output branch_taken, jal, jalr, stall_hazard, stall_mem,
        input  pc_sel, stall_if, flush_if, fetch_valid, redirect_count, bubble_count
    );

    modport slave (
        input  branch_taken, jal, jalr, stall_hazard, stall_mem,
        output pc_sel, stall_if, flush_if, fetch_valid, redirect_count, bubble_count
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencing: models imem latency, arbitrates decode redirects
// against stalls, and keeps redirect/bubble performance counters.
//
// state | meaning
// ------+--------------------------------------------------------------
// BOOT  | after reset; PC held so the first fetch is the reset PC
// WAIT  | imem read in flight; wcnt counts remaining wait cycles
// READY | instruction valid; advance, stall, or redirect
module fetch_ctrl #(
    parameter int XLEN     = 32,
    parameter int IMEM_LAT = 1,
    parameter int CNT_W    = 4
) (
    input logic         clk,
    input logic         rst,
    fetch_ctrl_if.slave fif
);
    localparam logic [1:0] SEL_PLUS4  = 2'd0;
    localparam logic [1:0] SEL_BRANCH = 2'd1;
    localparam logic [1:0] SEL_JAL    = 2'd2;
    localparam logic [1:0] SEL_JALR   = 2'd3;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  wcnt;
    logic [XLEN-1:0]   redirect_cnt;
    logic [XLEN-1:0]   bubble_cnt;

    logic              redirect;
    logic              take;
    logic [1:0]        redirect_sel;
    logic [1:0]        pc_sel;
    logic              stall_if;
    logic              flush_if;
    logic              fetch_valid;

    assign redirect = (state != BOOT) && (fif.jalr || fif.jal || fif.branch_taken);
    assign take     = redirect && !fif.stall_mem;

    always_comb begin
        redirect_sel = SEL_BRANCH;
        if (fif.jalr)
            redirect_sel = SEL_JALR;
        else if (fif.jal)
            redirect_sel = SEL_JAL;
    end

    always_comb begin
        pc_sel      = SEL_PLUS4;
        stall_if    = 1'b1;
        flush_if    = 1'b1;
        fetch_valid = 1'b0;
        case (state)
            WAIT: begin
                if (redirect) begin
                    pc_sel   = redirect_sel;
                    stall_if = !take;
                end
            end
            READY: begin
                fetch_valid = 1'b1;
                flush_if    = 1'b0;
                stall_if    = fif.stall_hazard || fif.stall_mem;
                if (redirect) begin
                    pc_sel = redirect_sel;
                    // A taken redirect squashes the fetched word; a blocked one just holds.
                    if (take) begin
                        stall_if    = 1'b0;
                        flush_if    = 1'b1;
                        fetch_valid = 1'b0;
                    end else begin
                        stall_if = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= BOOT;
            wcnt         <= '0;
            redirect_cnt <= '0;
            bubble_cnt   <= '0;
        end else begin
            if (take)
                redirect_cnt <= redirect_cnt + 1'b1;
            if (flush_if && state != BOOT)
                bubble_cnt <= bubble_cnt + 1'b1;

            case (state)
                BOOT: begin
                    if (IMEM_LAT > 1) begin
                        state <= WAIT;
                        wcnt  <= CNT_W'(IMEM_LAT - 1);
                    end else begin
                        state <= READY;
                    end
                end
                WAIT: begin
                    if (take) begin
                        state <= WAIT;
                        wcnt  <= CNT_W'(IMEM_LAT - 1);
                    end else begin
                        wcnt <= wcnt - 1'b1;
                        if (wcnt == CNT_W'(1))
                            state <= READY;
                    end
                end
                READY: begin
                    if (!stall_if) begin
                        if (IMEM_LAT > 1) begin
                            state <= WAIT;
                            wcnt  <= CNT_W'(IMEM_LAT - 1);
                        end else begin
                            state <= READY;
                        end
                    end
                end
                default: begin
                    state <= BOOT;
                    wcnt  <= '0;
                end
            endcase
        end
    end

    assign fif.pc_sel         = pc_sel;
    assign fif.stall_if       = stall_if;
    assign fif.flush_if       = flush_if;
    assign fif.fetch_valid    = fetch_valid;
    assign fif.redirect_count = redirect_cnt;
    assign fif.bubble_count   = bubble_cnt;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: three instances (latency 1, 3, 4) share one clock.
// Output bundle compared as {fetch_valid, flush_if, stall_if, pc_sel}.
module tb_fetch_ctrl;
    logic clk = 1'b0;
    logic rst1, rst3, rst4;

    always #5 clk = ~clk;

    fetch_ctrl_if #(.XLEN(32)) f1 ();
    fetch_ctrl_if #(.XLEN(32)) f3 ();
    fetch_ctrl_if #(.XLEN(32)) f4 ();

    fetch_ctrl #(.XLEN(32), .IMEM_LAT(1), .CNT_W(4)) u1 (.clk(clk), .rst(rst1), .fif(f1));
    fetch_ctrl #(.XLEN(32), .IMEM_LAT(3), .CNT_W(4)) u3 (.clk(clk), .rst(rst3), .fif(f3));
    fetch_ctrl #(.XLEN(32), .IMEM_LAT(4), .CNT_W(4)) u4 (.clk(clk), .rst(rst4), .fif(f4));

    wire [4:0] o1 = {f1.fetch_valid, f1.flush_if, f1.stall_if, f1.pc_sel};
    wire [4:0] o3 = {f3.fetch_valid, f3.flush_if, f3.stall_if, f3.pc_sel};
    wire [4:0] o4 = {f4.fetch_valid, f4.flush_if, f4.stall_if, f4.pc_sel};

    localparam logic [4:0] O_BOOT  = 5'b01100;
    localparam logic [4:0] O_WAIT  = 5'b01100;
    localparam logic [4:0] O_RDY   = 5'b10000;
    localparam logic [4:0] O_STALL = 5'b10100;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the edge; outputs are checked 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [4:0] exp3(input int t);
        return (t % 3 == 0) ? O_RDY : O_WAIT;
    endfunction

    initial begin
        rst1 = 1'b1; rst3 = 1'b1; rst4 = 1'b1;
        {f1.branch_taken, f1.jal, f1.jalr, f1.stall_hazard, f1.stall_mem} = '0;
        {f3.branch_taken, f3.jal, f3.jalr, f3.stall_hazard, f3.stall_mem} = '0;
        {f4.branch_taken, f4.jal, f4.jalr, f4.stall_hazard, f4.stall_mem} = '0;

        tick();
        tick();
        rst1 = 1'b0; rst3 = 1'b0; rst4 = 1'b0;
        settle();
        // t=0: all in BOOT
        chk("boot_o1", 32'(o1), 32'(O_BOOT));
        chk("boot_o3", 32'(o3), 32'(O_BOOT));
        chk("boot_o4", 32'(o4), 32'(O_BOOT));
        chk("boot_red1", f1.redirect_count, 32'd0);
        chk("boot_bub1", f1.bubble_count, 32'd0);

        for (int t = 1; t <= 9; t++) begin
            tick();
            if (t == 3) rst4 = 1'b0;
            settle();
            chk($sformatf("lat1_ready_t%0d", t), 32'(o1), 32'(O_RDY));
            chk($sformatf("lat3_pattern_t%0d", t), 32'(o3), 32'(exp3(t)));
            case (t)
                1, 2, 4, 5, 6: chk($sformatf("lat4_wait_t%0d", t), 32'(o4), 32'(O_WAIT));
                3:             chk("lat4_boot_after_rst", 32'(o4), 32'(O_BOOT));
                7:             chk("lat4_ready", 32'(o4), 32'(O_RDY));
                default: ;
            endcase
            if (t == 2) begin
                chk("lat4_bub_pre_rst", f4.bubble_count, 32'd1);
                rst4 = 1'b1;
            end
            if (t == 3) begin
                chk("lat4_bub_post_rst", f4.bubble_count, 32'd0);
                chk("lat4_red_post_rst", f4.redirect_count, 32'd0);
            end
        end

        // t=10: lat3 sits in its first WAIT; jal+branch together, JAL wins
        tick();
        settle();
        chk("lat1_bub_zero", f1.bubble_count, 32'd0);
        chk("lat3_bub_9cyc", f3.bubble_count, 32'd6);
        chk("lat3_wait1", 32'(o3), 32'(O_WAIT));
        f3.jal = 1'b1; f3.branch_taken = 1'b1;
        settle();
        chk("lat3_redir_jal", 32'(o3), 32'(5'b01010));

        // t=11..13: lat3 exact two WAITs after redirect; lat1 load-use hazard
        tick();
        f3.jal = 1'b0; f3.branch_taken = 1'b0;
        f1.stall_hazard = 1'b1;
        settle();
        chk("lat3_red_cnt", f3.redirect_count, 32'd1);
        chk("lat3_bub_redir", f3.bubble_count, 32'd7);
        chk("lat3_post_redir_w1", 32'(o3), 32'(O_WAIT));
        chk("lat1_hazard1", 32'(o1), 32'(O_STALL));

        tick();
        settle();
        chk("lat3_post_redir_w2", 32'(o3), 32'(O_WAIT));
        chk("lat1_hazard2", 32'(o1), 32'(O_STALL));

        tick();
        settle();
        chk("lat3_post_redir_rdy", 32'(o3), 32'(O_RDY));
        chk("lat1_hazard3", 32'(o1), 32'(O_STALL));
        chk("lat1_hazard_no_red", f1.redirect_count, 32'd0);
        f1.jalr = 1'b1;
        settle();
        chk("lat1_jalr_over_hazard", 32'(o1), 32'(5'b01011));

        tick();
        f1.jalr = 1'b0; f1.stall_hazard = 1'b0;
        settle();
        chk("lat1_red_after_jalr", f1.redirect_count, 32'd1);
        chk("lat1_bub_after_jalr", f1.bubble_count, 32'd1);
        chk("lat1_ready_after_jalr", 32'(o1), 32'(O_RDY));

        // stall_mem blocks a held branch for 4 cycles, then it is taken
        f1.stall_mem = 1'b1; f1.branch_taken = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            settle();
            chk($sformatf("lat1_blocked_o_%0d", k), 32'(o1), 32'(5'b10101));
            chk($sformatf("lat1_blocked_red_%0d", k), f1.redirect_count, 32'd1);
        end
        tick();
        f1.stall_mem = 1'b0;
        settle();
        chk("lat1_unblocked_o", 32'(o1), 32'(5'b01001));

        tick();
        f1.branch_taken = 1'b0;
        settle();
        chk("lat1_unblocked_red", f1.redirect_count, 32'd2);
        chk("lat1_unblocked_bub", f1.bubble_count, 32'd2);
        chk("lat1_final_ready", 32'(o1), 32'(O_RDY));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
